// File: rtl/keypad_pkg.sv
// Shared types and timing constants for the keypad emulator.
package keypad_pkg;

  // Phase sequence of one emulated key press.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS_BOUNCE,
    ST_HOLD,
    ST_RELEASE_BOUNCE,
    ST_GAP
  } state_e;

  // Key code: one-hot row in the upper nibble, one-hot column in the lower.
  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
  } key_t;

  localparam int unsigned CNT_W         = 24;
  localparam int unsigned BOUNCE_TOGGLE = 4;
  localparam int unsigned GAP_CYCLES    = 16;

  // A key is usable only if both nibbles select exactly one line.
  function automatic logic key_is_valid(input key_t k);
    return $onehot(k.row) && $onehot(k.col);
  endfunction

  // Counter preload for a hold phase; a zero hold behaves like one cycle.
  function automatic logic [CNT_W-1:0] hold_load(input logic [CNT_W-1:0] h);
    return (h == '0) ? '0 : h - CNT_W'(1);
  endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Command handshake and status bundle between a press sequencer and the emulator.
interface keypad_emulator_if;
  import keypad_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  key_t        cmd_key;
  logic [23:0] cmd_hold;
  logic [7:0]  cmd_bounce;
  logic        busy;
  logic        done;
  logic        cmd_error;

  modport master (
    output cmd_valid, cmd_key, cmd_hold, cmd_bounce,
    input  cmd_ready, busy, done, cmd_error
  );

  modport slave (
    input  cmd_valid, cmd_key, cmd_hold, cmd_bounce,
    output cmd_ready, busy, done, cmd_error
  );

endinterface

// File: rtl/cycle_down_counter.sv
// Loadable down counter that stops at zero; times each press phase.
module cycle_down_counter #(
  parameter int unsigned W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_value_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  // Load has priority over decrement; decrement saturates at zero.
  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/keypad_emulator.sv
// Emulates one matrix key: answers the scanner's row drive with the latched
// column while the contact is closed, including bounce at both press edges.
module keypad_emulator
  import keypad_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         keypad_row,
  output logic [3:0]         keypad_column,
  keypad_emulator_if.slave   cmd
);

  state_e            state_q, state_d;
  key_t              key_q, key_d;
  logic [CNT_W-1:0]  hold_q, hold_d;
  logic [7:0]        bounce_q, bounce_d;
  logic              error_q, error_d;

  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_load_value;
  logic [CNT_W-1:0]  cnt_value;
  logic              cnt_zero;
  logic              done_c;

  logic [CNT_W-1:0]  elapsed;
  logic              phase_odd;
  logic              contact;

  cycle_down_counter #(.W(CNT_W)) u_phase_counter (
    .clk          (clk),
    .rst_n        (reset),
    .load_i       (cnt_load),
    .load_value_i (cnt_load_value),
    .en_i         (state_q != ST_IDLE),
    .count_o      (cnt_value),
    .zero_o       (cnt_zero)
  );

  // Next state, command latching and phase-counter preload on each phase entry.
  always_comb begin
    state_d        = state_q;
    key_d          = key_q;
    hold_d         = hold_q;
    bounce_d       = bounce_q;
    error_d        = 1'b0;
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    done_c         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          if (key_is_valid(cmd.cmd_key)) begin
            key_d    = cmd.cmd_key;
            hold_d   = cmd.cmd_hold;
            bounce_d = cmd.cmd_bounce;
            cnt_load = 1'b1;
            if (cmd.cmd_bounce != 8'd0) begin
              state_d        = ST_PRESS_BOUNCE;
              cnt_load_value = CNT_W'(cmd.cmd_bounce) - CNT_W'(1);
            end else begin
              state_d        = ST_HOLD;
              cnt_load_value = hold_load(cmd.cmd_hold);
            end
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_PRESS_BOUNCE: begin
        if (cnt_zero) begin
          state_d        = ST_HOLD;
          cnt_load       = 1'b1;
          cnt_load_value = hold_load(hold_q);
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          if (bounce_q != 8'd0) begin
            state_d        = ST_RELEASE_BOUNCE;
            cnt_load_value = CNT_W'(bounce_q) - CNT_W'(1);
          end else begin
            state_d        = ST_GAP;
            cnt_load_value = CNT_W'(GAP_CYCLES - 1);
          end
        end
      end
      ST_RELEASE_BOUNCE: begin
        if (cnt_zero) begin
          state_d        = ST_GAP;
          cnt_load       = 1'b1;
          cnt_load_value = CNT_W'(GAP_CYCLES - 1);
        end
      end
      ST_GAP: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
          done_c  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched-command registers; reset aborts any sequence at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      key_q    <= '0;
      hold_q   <= '0;
      bounce_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      hold_q   <= hold_d;
      bounce_q <= bounce_d;
      error_q  <= error_d;
    end
  end

  // Contact model: bounce phases alternate every BOUNCE_TOGGLE cycles, press
  // bounce starting closed and release bounce starting open.
  always_comb begin
    elapsed   = CNT_W'(bounce_q) - CNT_W'(1) - cnt_value;
    phase_odd = ((elapsed / CNT_W'(BOUNCE_TOGGLE)) % CNT_W'(2)) != '0;
    contact   = (state_q == ST_HOLD)
             || ((state_q == ST_PRESS_BOUNCE)   && !phase_odd)
             || ((state_q == ST_RELEASE_BOUNCE) &&  phase_odd);
    keypad_column = (contact && ((keypad_row & key_q.row) != 4'b0000))
                  ? key_q.col : 4'b0000;
  end

  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign cmd.busy      = (state_q != ST_IDLE);
  assign cmd.done      = done_c;
  assign cmd.cmd_error = error_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Randomized self-checking bench: a timeline model of each accepted press
// predicts contact, column, busy, ready, done and cmd_error every cycle.
module tb_keypad_emulator;

  localparam int TOGGLE = 4;
  localparam int GAP    = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] keypad_row;
  logic [3:0] keypad_column;

  keypad_emulator_if cmd_if ();

  keypad_emulator dut (
    .clk           (clk),
    .reset         (reset),
    .keypad_row    (keypad_row),
    .keypad_column (keypad_column),
    .cmd           (cmd_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic contact;
    logic done;
  } step_t;

  step_t      plan_q[$];
  logic [7:0] plan_key;
  bit         err_now, err_next, accepted_now;
  int         n_checks, n_errors, cyc, acc_cyc, done_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit key_ok(input logic [7:0] k);
    return ($countones(k[7:4]) == 1) && ($countones(k[3:0]) == 1);
  endfunction

  // Expected contact timeline of a full press, one entry per cycle after accept.
  task automatic build_plan(input logic [23:0] hold, input logic [7:0] bounce);
    int h;
    h = (hold == 0) ? 1 : int'(hold);
    for (int i = 0; i < int'(bounce); i++) plan_q.push_back('{contact: ((i / TOGGLE) % 2) == 0, done: 1'b0});
    for (int i = 0; i < h; i++)            plan_q.push_back('{contact: 1'b1, done: 1'b0});
    for (int i = 0; i < int'(bounce); i++) plan_q.push_back('{contact: ((i / TOGGLE) % 2) == 1, done: 1'b0});
    for (int i = 0; i < GAP; i++)          plan_q.push_back('{contact: 1'b0, done: (i == GAP - 1)});
  endtask

  function automatic logic [3:0] exp_column(input step_t s, input logic [3:0] row);
    return (s.contact && ((row & plan_key[7:4]) != 4'b0)) ? plan_key[3:0] : 4'b0;
  endfunction

  // One clock cycle: compare outputs mid-cycle, then advance the model at the edge.
  task automatic tick();
    step_t s;
    bit    busy_e;
    keypad_row = 4'($urandom);
    @(negedge clk);
    if (plan_q.size() != 0) begin s = plan_q[0]; busy_e = 1'b1; end
    else begin s = '{contact: 1'b0, done: 1'b0}; busy_e = 1'b0; end
    check("column", {28'b0, keypad_column}, {28'b0, exp_column(s, keypad_row)});
    check("busy", {31'b0, cmd_if.busy}, {31'b0, busy_e});
    check("cmd_ready", {31'b0, cmd_if.cmd_ready}, {31'b0, !busy_e});
    check("done", {31'b0, cmd_if.done}, {31'b0, s.done});
    check("cmd_error", {31'b0, cmd_if.cmd_error}, {31'b0, err_now});
    if (cmd_if.done) done_cyc = cyc;
    keypad_row = 4'($urandom);
    #1;
    check("column_same_cycle", {28'b0, keypad_column}, {28'b0, exp_column(s, keypad_row)});
    accepted_now = 1'b0;
    err_next     = 1'b0;
    if (busy_e) begin
      void'(plan_q.pop_front());
    end else if (cmd_if.cmd_valid) begin
      accepted_now = 1'b1;
      acc_cyc      = cyc;
      if (key_ok(cmd_if.cmd_key)) begin
        plan_key = cmd_if.cmd_key;
        build_plan(cmd_if.cmd_hold, cmd_if.cmd_bounce);
      end else begin
        err_next = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    err_now = err_next;
    cyc++;
  endtask

  task automatic scramble_cmd();
    cmd_if.cmd_key    = 8'($urandom);
    cmd_if.cmd_hold   = 24'($urandom);
    cmd_if.cmd_bounce = 8'($urandom);
  endtask

  // Offer a command until accepted; optionally keep cmd_valid high afterwards.
  task automatic send(input logic [7:0] key, input logic [23:0] hold, input logic [7:0] bounce,
                      input bit keep_valid);
    int n;
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_key    = key;
    cmd_if.cmd_hold   = hold;
    cmd_if.cmd_bounce = bounce;
    n = 0;
    do begin
      tick();
      n++;
    end while (!accepted_now && n < 5000);
    if (!accepted_now) check("accept_timeout", 32'd0, 32'd1);
    cmd_if.cmd_valid = keep_valid;
    if (!keep_valid) scramble_cmd();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((plan_q.size() != 0 || err_now) && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] k;
    n_checks = 0; n_errors = 0; cyc = 0; acc_cyc = 0; done_cyc = -1;
    err_now = 1'b0; err_next = 1'b0; accepted_now = 1'b0; plan_key = 8'h00;
    reset = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    scramble_cmd();
    keypad_row = 4'hF;
    #1;
    check("reset_column", {28'b0, keypad_column}, 32'd0);
    check("reset_ready", {31'b0, cmd_if.cmd_ready}, 32'd1);
    check("reset_busy", {31'b0, cmd_if.busy}, 32'd0);
    check("reset_done", {31'b0, cmd_if.done}, 32'd0);
    check("reset_error", {31'b0, cmd_if.cmd_error}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) tick();

    // Clean press on row 3 / column 1: done lands 116 cycles after the accept.
    send(8'b1000_0010, 24'd100, 8'd0, 1'b0);
    wait_idle();
    check("done_latency", 32'(done_cyc - acc_cyc), 32'd116);

    // Bouncy press on row 0 / column 2.
    send(8'b0001_0100, 24'd50, 8'd12, 1'b0);
    wait_idle();

    // Two rows selected: rejected with a single error pulse.
    send(8'b0011_0010, 24'd20, 8'd3, 1'b0);
    wait_idle();

    // Edge durations: zero hold, single-cycle bounce, longest bounce.
    send(8'b0001_0001, 24'd0, 8'd1, 1'b0);
    wait_idle();
    send(8'b1000_1000, 24'd1, 8'd5, 1'b0);
    wait_idle();
    send(8'b0100_0010, 24'd3, 8'd255, 1'b0);
    wait_idle();
    send(8'b0000_0100, 24'd5, 8'd0, 1'b0);
    wait_idle();

    // Back-to-back: second command waits while valid stays high.
    send(8'b0100_0001, 24'd30, 8'd3, 1'b1);
    cmd_if.cmd_key    = 8'b0010_0100;
    cmd_if.cmd_hold   = 24'd10;
    cmd_if.cmd_bounce = 8'd2;
    send(8'b0010_0100, 24'd10, 8'd2, 1'b0);
    check("second_accept_after_done", 32'(acc_cyc), 32'(done_cyc + 1));
    wait_idle();

    // Randomized commands, sometimes offered while the previous press runs.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) k = 8'($urandom);
      else k = {4'(1 << $urandom_range(0, 3)), 4'(1 << $urandom_range(0, 3))};
      send(k, 24'($urandom_range(0, 30)), ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 20)),
           1'b0);
      if ($urandom_range(0, 2) != 0) wait_idle();
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_idle();

    // Reset during HOLD: outputs drop immediately and no done follows.
    send(8'b0100_0001, 24'd200, 8'd0, 1'b0);
    repeat (20) tick();
    keypad_row = 4'b0100;
    #1;
    check("pre_reset_column", {28'b0, keypad_column}, 32'b0001);
    reset = 1'b0;
    #1;
    check("abort_column", {28'b0, keypad_column}, 32'd0);
    check("abort_ready", {31'b0, cmd_if.cmd_ready}, 32'd1);
    check("abort_busy", {31'b0, cmd_if.busy}, 32'd0);
    check("abort_done", {31'b0, cmd_if.done}, 32'd0);
    plan_q.delete();
    plan_key = 8'h00;
    err_now  = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
    send(8'b0010_1000, 24'd8, 8'd6, 1'b0);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port keypad_row, input, 4, one-hot row drive from the scanner under test.
REQ-004 SHALL have port keypad_column, output, 4, column sense returned to the scanner.
REQ-005 SHALL have port cmd_valid, input, 1, press command offered.
REQ-006 SHALL have port cmd_ready, output, 1, emulator accepts a command this cycle.
REQ-007 SHALL have port cmd_key, input, 8, key code {row one-hot[7:4], column one-hot[3:0]}, e.g. 8'b1000_0010 = row 3, col 1.
REQ-008 SHALL have port cmd_hold, input, 24, stable-closed cycles (0 treated as 1).
REQ-009 SHALL have port cmd_bounce, input, 8, bounce cycles at each edge of the press (0 = clean).
REQ-010 SHALL have port busy, output, 1, press sequence in progress.
REQ-011 SHALL have port done, output, 1, one-cycle pulse when a sequence completes.
REQ-012 SHALL have port cmd_error, output, 1, one-cycle pulse on a rejected command.

Function
REQ-013 Handshake: SHALL accept a command when cmd_valid && cmd_ready on a rising edge; cmd_ready = 1 only in IDLE.
REQ-014 SHALL latch cmd_key, cmd_hold, cmd_bounce on acceptance; later input changes SHALL have no effect on the active sequence.
REQ-015 SHALL reject a key whose row or column nibble is not exactly one-hot: cmd_error pulses the cycle after acceptance, state remains IDLE, contact stays open.
REQ-016 States SHALL be IDLE, PRESS_BOUNCE, HOLD, RELEASE_BOUNCE, GAP.
REQ-017 IDLE -> PRESS_BOUNCE on valid accept if cmd_bounce != 0, else directly to HOLD.
REQ-018 PRESS_BOUNCE SHALL last cmd_bounce cycles; contact toggles every BOUNCE_TOGGLE cycles starting closed; then -> HOLD.
REQ-019 HOLD SHALL keep contact closed for max(cmd_hold,1) cycles; then -> RELEASE_BOUNCE if cmd_bounce != 0, else -> GAP.
REQ-020 RELEASE_BOUNCE SHALL last cmd_bounce cycles, toggling starting open; then -> GAP.
REQ-021 GAP SHALL hold contact open for GAP_CYCLES cycles, pulse done on its final cycle, then -> IDLE.
REQ-022 keypad_column SHALL be combinational: column nibble of the latched key when contact is closed and (keypad_row & row nibble) != 0; otherwise 4'b0000.
REQ-023 Column response SHALL follow keypad_row within the same cycle (zero latency); multiple active rows SHALL still return only the latched column.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 The internal cycle counter SHALL be 24 bits, load on state entry, decrement by 1, and SHALL NOT wrap below zero.

Reset
REQ-026 On reset low, state SHALL become IDLE immediately, contact open, keypad_column = 0, cmd_ready = 1, busy = 0, done = 0, cmd_error = 0, latched key = 0.
REQ-027 Reset asserted mid-sequence SHALL abort it with no done pulse; the first accept after release SHALL start a fresh sequence.

Structure
REQ-028 Package keypad_pkg SHALL hold the state enum, key-code typedef, BOUNCE_TOGGLE = 4, and GAP_CYCLES = 16.
REQ-029 One sub-module, cycle_down_counter (load, enable, zero flag), SHALL provide phase timing.

Verification
REQ-030 Key 8'b1000_0010, hold 100, bounce 0: keypad_column = 4'b0010 exactly when keypad_row[3] = 1 for 100 cycles; done pulses 116 cycles after accept.
REQ-031 Key 8'b0001_0100, hold 50, bounce 12: column toggles every 4 cycles for 12 cycles on row 0, then is stable for 50 cycles, then toggles for 12; busy high throughout.
REQ-032 Key 8'b0011_0010 (two rows): cmd_error pulses once, busy stays 0, column stays 0.
REQ-033 cmd_valid held high with a new key during HOLD: cmd_ready = 0, the second key is accepted only after done, and the first key is unaffected.
REQ-034 Reset dropped during HOLD of key 8'b0100_0001: column becomes 0 asynchronously, no done pulse, cmd_ready = 1.
REQ-035 Closed loop with keypad_scanner_and_debouncer: press 1 then 2, each held 12 ms equivalent -> most_recent_key = 8'b0001_0010, second_most_recent_key = 8'b1000_0010.
